// File: rtl/mem_access_unit_if.sv
// Core-side request/response and memory-side bus bundle for mem_access_unit.
// mem_be exists only when MAU_BYTE_EN is defined.
interface mem_access_unit_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) ();
  localparam int unsigned NB = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_address;
  logic [XLEN-1:0]   mem_data_out;
  logic [XLEN-1:0]   mem_data_in;
  logic              mem_ack;
`ifdef MAU_BYTE_EN
  logic [NB-1:0]     mem_be;
`endif

  // Unit side: accepts core requests and masters the memory port.
  modport slave (
`ifdef MAU_BYTE_EN
    output mem_be,
`endif
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  mem_data_in, mem_ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_req, mem_we, mem_address, mem_data_out
  );

  // Environment side: core issuing requests plus the memory responder.
  modport master (
`ifdef MAU_BYTE_EN
    input  mem_be,
`endif
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    output mem_data_in, mem_ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_req, mem_we, mem_address, mem_data_out
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multicycle load/store unit: alignment/width checks, req/ack memory bus, load extension.
// MAU_BYTE_EN: byte-strobed stores; otherwise stores use a read-modify-write sequence.
module mem_access_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  mem_access_unit_if.slave  bus
);
  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned LW = $clog2(NB);

  typedef enum logic [2:0] {IDLE, READ, WRITE, RMW_READ, RMW_WRITE, RESP} state_t;

  state_t            state, state_n;
  logic              ready_q, ready_n;
  logic              rsp_valid_q, rsp_valid_n;
  logic              rsp_err_q, rsp_err_n;
  logic [XLEN-1:0]   rdata_q, rdata_n;
  logic              mem_req_q, mem_req_n;
  logic              mem_we_q, mem_we_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [XLEN-1:0]   dout_q, dout_n;
  logic [2:0]        f3_q, f3_n;
  logic [LW-1:0]     off_q, off_n;
`ifdef MAU_BYTE_EN
  logic [NB-1:0]     be_q, be_n;
`else
  logic [XLEN-1:0]   wdata_q, wdata_n;
`endif

  function automatic logic width_legal(input logic wr, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010: width_legal = 1'b1;
      3'b100, 3'b101:         width_legal = !wr;
      3'b011:                 width_legal = (XLEN == 64);
      3'b110:                 width_legal = (XLEN == 64) && !wr;
      default:                width_legal = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] a);
    case (f3[1:0])
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = |a[1:0];
      2'b11:   misaligned = |a;
      default: misaligned = 1'b0;
    endcase
  endfunction

  // Shift the addressed lane down, then sign- or zero-extend per funct3.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] word,
                                               input logic [2:0] f3,
                                               input logic [LW-1:0] off);
    logic [XLEN-1:0] s;
    s = word >> {off, 3'b000};
    case (f3)
      3'b000:  load_ext = XLEN'($signed(s[7:0]));
      3'b001:  load_ext = XLEN'($signed(s[15:0]));
      3'b010:  load_ext = XLEN'($signed(s[31:0]));
      3'b100:  load_ext = XLEN'(s[7:0]);
      3'b101:  load_ext = XLEN'(s[15:0]);
      3'b110:  load_ext = XLEN'(s[31:0]);
      default: load_ext = s;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_repl(input logic [XLEN-1:0] w, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   store_repl = {NB{w[7:0]}};
      2'b01:   store_repl = {(NB/2){w[15:0]}};
      2'b10:   store_repl = {(NB/4){w[31:0]}};
      default: store_repl = w;
    endcase
  endfunction

  function automatic logic [NB-1:0] store_mask(input logic [2:0] f3, input logic [LW-1:0] off);
    case (f3[1:0])
      2'b00:   store_mask = NB'(1) << off;
      2'b01:   store_mask = NB'(3) << off;
      2'b10:   store_mask = NB'(15) << off;
      default: store_mask = '1;
    endcase
  endfunction

`ifndef MAU_BYTE_EN
  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old_w,
                                            input logic [XLEN-1:0] new_w,
                                            input logic [NB-1:0] be);
    for (int i = 0; i < NB; i++)
      merge[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      f3_q        <= '0;
      off_q       <= '0;
`ifdef MAU_BYTE_EN
      be_q        <= '0;
`else
      wdata_q     <= '0;
`endif
    end else begin
      state       <= state_n;
      ready_q     <= ready_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_err_q   <= rsp_err_n;
      rdata_q     <= rdata_n;
      mem_req_q   <= mem_req_n;
      mem_we_q    <= mem_we_n;
      addr_q      <= addr_n;
      dout_q      <= dout_n;
      f3_q        <= f3_n;
      off_q       <= off_n;
`ifdef MAU_BYTE_EN
      be_q        <= be_n;
`else
      wdata_q     <= wdata_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    ready_n     = ready_q;
    rsp_valid_n = rsp_valid_q;
    rsp_err_n   = rsp_err_q;
    rdata_n     = rdata_q;
    mem_req_n   = mem_req_q;
    mem_we_n    = mem_we_q;
    addr_n      = addr_q;
    dout_n      = dout_q;
    f3_n        = f3_q;
    off_n       = off_q;
`ifdef MAU_BYTE_EN
    be_n        = be_q;
`else
    wdata_n     = wdata_q;
`endif
    case (state)
      IDLE: if (bus.req_valid) begin
        ready_n = 1'b0;
        f3_n    = bus.req_funct3;
        off_n   = bus.req_addr[LW-1:0];
        if (!width_legal(bus.req_write, bus.req_funct3) ||
            misaligned(bus.req_funct3, bus.req_addr[2:0])) begin
          state_n     = RESP;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rdata_n     = '0;
        end else begin
          mem_req_n = 1'b1;
          addr_n    = bus.req_addr & ~ADDR_W'(NB - 1);
          mem_we_n  = 1'b0;
          if (!bus.req_write) begin
            state_n = READ;
          end else begin
`ifdef MAU_BYTE_EN
            state_n  = WRITE;
            mem_we_n = 1'b1;
            dout_n   = store_repl(bus.req_wdata, bus.req_funct3);
            be_n     = store_mask(bus.req_funct3, bus.req_addr[LW-1:0]);
`else
            state_n  = RMW_READ;
            wdata_n  = bus.req_wdata;
`endif
          end
        end
      end
      READ: if (bus.mem_ack) begin
        state_n     = RESP;
        mem_req_n   = 1'b0;
        rsp_valid_n = 1'b1;
        rsp_err_n   = 1'b0;
        rdata_n     = load_ext(bus.mem_data_in, f3_q, off_q);
      end
      WRITE, RMW_WRITE: if (bus.mem_ack) begin
        state_n     = RESP;
        mem_req_n   = 1'b0;
        mem_we_n    = 1'b0;
        rsp_valid_n = 1'b1;
        rsp_err_n   = 1'b0;
        rdata_n     = '0;
`ifdef MAU_BYTE_EN
        be_n        = '0;
`endif
      end
      RMW_READ: if (bus.mem_ack) begin
        state_n  = RMW_WRITE;
        mem_we_n = 1'b1;
`ifndef MAU_BYTE_EN
        dout_n   = merge(bus.mem_data_in, store_repl(wdata_q, f3_q), store_mask(f3_q, off_q));
`endif
      end
      RESP: begin
        state_n     = IDLE;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;
        ready_n     = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.req_ready    = ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.rsp_rdata    = rdata_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_address  = addr_q;
  assign bus.mem_data_out = dout_q;
`ifdef MAU_BYTE_EN
  assign bus.mem_be       = be_q;
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (XLEN=32) with a wait-state memory responder.
module tb_mem_access_unit;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 32;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();
  mem_access_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          busy = 1'b0;

  int          wait_cycles = 0;
  int          wcnt = 0;
  int          req_cycles = 0;
  int          wr_count = 0;
  bit          held = 1'b0;
  logic [31:0] mem_word = '0;
  logic [31:0] hold_addr = '0;
  logic [31:0] last_rd_addr = '0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic [3:0]  last_wr_be = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor: pops one expectation per rsp_valid pulse.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (busy) chk("ready_low_while_busy", 64'(bus.req_ready), 64'd0);
    if (bus.rsp_valid === 1'b1) begin
      busy = 1'b0;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
      end else begin
        e = sb.pop_front();
        chk({e.name, "_err"}, 64'(bus.rsp_err), 64'(e.err));
        chk({e.name, "_rdata"}, 64'(bus.rsp_rdata), 64'(e.rdata));
        chk({e.name, "_latency"}, 64'(cyc - acc_cyc + 1), 64'(e.lat));
      end
    end
  end

  // Memory responder: acks after wait_cycles request cycles, records accesses.
  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_data_in = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      bus.mem_data_in = 32'hDEAD_DEAD;
      if (bus.mem_req === 1'b1) begin
        req_cycles++;
        if (held) chk("mem_addr_stable", 64'(bus.mem_address), 64'(hold_addr));
        hold_addr = bus.mem_address;
        held = 1'b1;
        if (wcnt >= wait_cycles) begin
          bus.mem_ack = 1'b1;
          bus.mem_data_in = mem_word;
          wcnt = 0;
          held = 1'b0;
          if (bus.mem_we) begin
            wr_count++;
            last_wr_addr = bus.mem_address;
            last_wr_data = bus.mem_data_out;
`ifdef MAU_BYTE_EN
            last_wr_be = bus.mem_be;
            for (int i = 0; i < 4; i++)
              if (bus.mem_be[i]) mem_word[8*i +: 8] = bus.mem_data_out[8*i +: 8];
`else
            mem_word = bus.mem_data_out;
`endif
          end else begin
            last_rd_addr = bus.mem_address;
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
        held = 1'b0;
      end
    end
  end

  task automatic issue(input string name, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic eerr, input logic [31:0] erdata, input int elat);
    exp_t e;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    e.name = name; e.err = eerr; e.rdata = erdata; e.lat = elat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.req_valid = 1'b0;
    busy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no response expected rsp_valid within 40 cycles", name);
      sb.delete();
      busy = 1'b0;
    end
  endtask

  initial begin
    int n;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_mem_address", 64'(bus.mem_address), 64'd0);
    chk("rst_mem_data_out", 64'(bus.mem_data_out), 64'd0);
`ifdef MAU_BYTE_EN
    chk("rst_mem_be", 64'(bus.mem_be), 64'd0);
`endif
    resetn = 1'b1;

    // Loads with varied lanes, extension and wait states.
    mem_word = 32'h80FF_1234; wait_cycles = 0;
    issue("lb", 1'b0, 3'b000, 32'h103, '0, 1'b0, 32'hFFFF_FF80, 2);
    chk("lb_mem_address", 64'(last_rd_addr), 64'h100);
    mem_word = 32'h8001_0000; wait_cycles = 3;
    issue("lhu", 1'b0, 3'b101, 32'h102, '0, 1'b0, 32'h0000_8001, 5);
    wait_cycles = 1;
    issue("lh", 1'b0, 3'b001, 32'h102, '0, 1'b0, 32'hFFFF_8001, 3);
    mem_word = 32'hDEAD_BEEF; wait_cycles = 0;
    issue("lw", 1'b0, 3'b010, 32'h104, '0, 1'b0, 32'hDEAD_BEEF, 2);
    chk("lw_mem_address", 64'(last_rd_addr), 64'h104);
    mem_word = 32'h1122_3344;
    issue("lbu", 1'b0, 3'b100, 32'h101, '0, 1'b0, 32'h0000_0033, 2);

    // Errors: misaligned or illegal widths never reach memory.
    n = req_cycles;
    issue("lw_misaligned", 1'b0, 3'b010, 32'h101, '0, 1'b1, 32'h0, 1);
    issue("ld_xlen32", 1'b0, 3'b011, 32'h100, '0, 1'b1, 32'h0, 1);
    issue("lwu_xlen32", 1'b0, 3'b110, 32'h100, '0, 1'b1, 32'h0, 1);
    issue("store_f3_100", 1'b1, 3'b100, 32'h100, 32'h55, 1'b1, 32'h0, 1);
    issue("sh_misaligned", 1'b1, 3'b001, 32'h203, 32'h1234, 1'b1, 32'h0, 1);
    chk("err_no_mem_req", 64'(req_cycles), 64'(n));

    // Stores.
    n = wr_count;
`ifdef MAU_BYTE_EN
    mem_word = 32'h0;
    issue("sh", 1'b1, 3'b001, 32'h206, 32'h0000_BEEF, 1'b0, 32'h0, 2);
    chk("sh_wr_addr", 64'(last_wr_addr), 64'h204);
    chk("sh_wr_data", 64'(last_wr_data), 64'hBEEF_BEEF);
    chk("sh_wr_be", 64'(last_wr_be), 64'b1100);
    issue("sb", 1'b1, 3'b000, 32'h201, 32'h0000_00AA, 1'b0, 32'h0, 2);
    chk("sb_wr_data", 64'(last_wr_data), 64'hAAAA_AAAA);
    chk("sb_wr_be", 64'(last_wr_be), 64'b0010);
`else
    mem_word = 32'h1122_3344;
    issue("sb", 1'b1, 3'b000, 32'h201, 32'h0000_00AA, 1'b0, 32'h0, 3);
    chk("sb_wr_addr", 64'(last_wr_addr), 64'h200);
    chk("sb_wr_data", 64'(last_wr_data), 64'h1122_AA44);
    mem_word = 32'h5566_7788;
    issue("sh", 1'b1, 3'b001, 32'h206, 32'h0000_BEEF, 1'b0, 32'h0, 3);
    chk("sh_wr_addr", 64'(last_wr_addr), 64'h204);
    chk("sh_wr_data", 64'(last_wr_data), 64'hBEEF_7788);
`endif
    chk("store_wr_count", 64'(wr_count), 64'(n + 2));

    // Reset while a load waits for ack: request is dropped silently.
    wait_cycles = 100;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h300; bus.req_wdata = '0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstmid_mem_req_active", 64'(bus.mem_req), 64'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("rstmid_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rstmid_mem_req", 64'(bus.mem_req), 64'd0);
    resetn = 1'b1;
    repeat (10) @(negedge clk);

    // Normal operation resumes after the aborted access.
    mem_word = 32'h0000_007F; wait_cycles = 0;
    issue("lb_after_reset", 1'b0, 3'b000, 32'h100, '0, 1'b0, 32'h0000_007F, 2);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multicycle load/store unit between the core's execute/memory stage and a variable-latency memory port. Accepts one load or store per handshake, checks alignment, drives a request/acknowledge memory bus, and returns sign/zero-extended load data. Generalises the core's fixed single-cycle word bus to parametrised data width, wait-state memories, and sub-word accesses.

## Interface
- XLEN, 32: data width, 32 or 64; byte lanes NB = XLEN/8.
- ADDR_W, 32: byte address width.
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V width/sign code (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, low bytes used.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal-width request; valid with rsp_valid.
- mem_req  out  1  memory access request, held until mem_ack.
- mem_we  out  1  write enable, valid with mem_req.
- mem_address  out  ADDR_W  lane-aligned address (low log2(NB) bits zero).
- mem_data_out  out  XLEN  write data.
- mem_data_in  in  XLEN  read data, valid when mem_ack.
- mem_ack  in  1  access complete this cycle.
- mem_be  out  NB  byte strobes (only with MAU_BYTE_EN).

## Operation
- States: IDLE, READ, WRITE, RMW_READ, RMW_WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch funct3, write flag, addr, wdata; decode.
- Legal widths: 000/001/010/100/101 always; 011 and 110 only when XLEN=64; store legal only with 000/001/010/011. Otherwise error.
- Alignment: H needs addr[0]=0, W addr[1:0]=0, D addr[2:0]=0.
- Error -> RESP directly, no memory cycle, rsp_err=1, rsp_rdata=0.
- Load -> READ: mem_req=1, mem_we=0 until mem_ack; capture mem_data_in on ack, select lane by addr[log2(NB)-1:0], sign-extend (B/H/W) or zero-extend (BU/HU/WU/D); -> RESP.
- Store -> WRITE (with macro) or RMW_READ (without); see Configuration.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Outputs registered; mem_address/mem_data_out/mem_we stable while mem_req high.

## Timing
- Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_req=0, mem_we=0, mem_address=0, mem_data_out=0, mem_be=0.
- Accept at edge N; mem_req high from cycle N+1.
- mem_ack sampled at edge; ack in first request cycle gives rsp_valid in cycle N+2 (min load/store latency 2; RMW store min 3). Each wait state adds one cycle.
- Error: rsp_valid in cycle N+1.
- mem_ack outside READ/WRITE/RMW states ignored.
- No new request accepted before RESP completes; req_ready low from N+1 through RESP cycle.
- resetn low mid-access: IDLE on that edge, mem_req dropped, latched request discarded, no response.

## Configuration
- MAU_BYTE_EN defined: mem_be port present; store goes IDLE -> WRITE; mem_data_out = store data replicated across lanes; mem_be has ones on written lanes only (B: 1 bit, H: 2, W: 4, D: all).
- Undefined: no mem_be port; store does RMW_READ (mem_we=0, capture word on ack) then RMW_WRITE (mem_we=1, full word with target bytes merged, others preserved) -> RESP. A reset between phases leaves memory unmodified.

## Test plan
- XLEN=32, LB addr 0x103, mem_data_in 0x80FF_1234 with ack immediately -> rsp_valid at N+2, rsp_rdata 0xFFFF_FF80, mem_address 0x100.
- LHU addr 0x102, data 0x8001_0000, ack after 3 wait cycles -> rsp_rdata 0x0000_8001, rsp_valid at N+5, req_ready low until then.
- LW addr 0x101 -> no mem_req, rsp_valid at N+1, rsp_err=1, rsp_rdata 0; LD (011) at XLEN=32 -> same.
- With MAU_BYTE_EN, SH addr 0x206 wdata 0x0000_BEEF -> mem_we=1, mem_address 0x204, mem_be 4'b1100, mem_data_out 0xBEEF_BEEF.
- Without MAU_BYTE_EN, SB addr 0x201 wdata 0xAA, memory word 0x1122_3344 -> read then write 0x1122_AA44, rsp_err=0.
- resetn low while READ waits for ack -> next cycle req_ready=1, mem_req=0, no rsp_valid ever for that request.
